// File: rtl/tdm_stream_mux.sv
// Time-division multiplexer: rotates over the enabled input channels, holding each
// for a latched number of cycles, and marks the start of every slot and rotation.
module tdm_stream_mux #(
   parameter int DATA_W = 16,
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic [CNT_W-1:0]           dwell_cycles,
   input  logic [NUM_CH-1:0]          ch_mask,
   input  logic [NUM_CH*DATA_W-1:0]   ds_in,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(NUM_CH)-1:0]  out_ch,
   output logic                       out_valid,
   output logic                       slot_start,
   output logic                       frame_start
);

   localparam int CH_W = $clog2(NUM_CH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    dwell_q, dwell_d;
   logic                first_slot_q, first_slot_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [CH_W-1:0]     out_ch_q, out_ch_d;
   logic                out_valid_q, out_valid_d;
   logic                slot_start_q, slot_start_d;
   logic                frame_start_q, frame_start_d;

   logic [DATA_W-1:0]   ch_data [NUM_CH];
   logic [NUM_CH-1:0]   above_mask;
   logic [CNT_W-1:0]    dwell_in;
   logic [CH_W-1:0]     next_ch;
   logic                slot_end;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]    = ds_in[gi*DATA_W +: DATA_W];
      assign above_mask[gi] = ch_mask[gi] && (CH_W'(gi) > ch_q);
   end

   function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
      logic [CH_W-1:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) r = CH_W'(i);
      end
      return r;
   endfunction

   // No enabled channel above the current one means the search wraps to a new rotation.
   assign next_ch  = (|above_mask) ? lowest_set(above_mask) : lowest_set(ch_mask);
   assign dwell_in = (dwell_cycles == '0) ? CNT_W'(1) : dwell_cycles;
   assign slot_end = (cnt_q == dwell_q - CNT_W'(1));

   always_comb begin
      state_d       = state_q;
      ch_d          = ch_q;
      cnt_d         = cnt_q;
      dwell_d       = dwell_q;
      first_slot_d  = first_slot_q;
      out_data_d    = out_data_q;
      out_ch_d      = out_ch_q;
      out_valid_d   = 1'b0;
      slot_start_d  = 1'b0;
      frame_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (en && (|ch_mask)) begin
               state_d      = RUN;
               ch_d         = lowest_set(ch_mask);
               dwell_d      = dwell_in;
               first_slot_d = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               out_data_d    = ch_data[ch_q];
               out_ch_d      = ch_q;
               out_valid_d   = 1'b1;
               slot_start_d  = (cnt_q == '0);
               frame_start_d = (cnt_q == '0) && first_slot_q;
               if (slot_end) begin
                  cnt_d   = '0;
                  dwell_d = dwell_in;
                  if (ch_mask == '0) begin
                     state_d = IDLE;
                  end else begin
                     ch_d         = next_ch;
                     first_slot_d = !(|above_mask);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ch_q          <= '0;
         cnt_q         <= '0;
         dwell_q       <= CNT_W'(1);
         first_slot_q  <= 1'b0;
         out_data_q    <= '0;
         out_ch_q      <= '0;
         out_valid_q   <= 1'b0;
         slot_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_q          <= ch_d;
         cnt_q         <= cnt_d;
         dwell_q       <= dwell_d;
         first_slot_q  <= first_slot_d;
         out_data_q    <= out_data_d;
         out_ch_q      <= out_ch_d;
         out_valid_q   <= out_valid_d;
         slot_start_q  <= slot_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign out_data    = out_data_q;
   assign out_ch      = out_ch_q;
   assign out_valid   = out_valid_q;
   assign slot_start  = slot_start_q;
   assign frame_start = frame_start_q;

endmodule
